os_generator: RTL and testbench
===============================

# os_generator

Transmit-side ordered-set generator for the PCIe RX/TX LTSSM. Driven by the main LTSSM's substate, it emits one 128-bit TS1, TS2 or Idle ordered set per handshake toward the lane serializer, filling in link and lane numbers, rate ID and upconfigure capability. It counts the sets accepted in the current substate and flags when the transmit minimum for that substate has been met. It is the peer of the receive-side ordered-set checker and uses the same substate encoding and byte layout.

## Interface
- DEVICETYPE, 0: 0 = downstream port, 1 = upstream port.
- POLL_ACTIVE_MIN, 1024: accepted TS1 count required in pollingActive.
- TS_MIN, 16: accepted set count required in pollingConfiguration, configurationComplete and configurationIdle.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- substate  in  4  LTSSM substate: 0 detectQuiet, 1 detectActive, 2 pollingActive, 3 pollingConfiguration, 4 cfgLinkWidthStart, 5 cfgLinkWidthAccept, 6 cfgLanenumWait, 7 cfgLanenumAccept, 8 cfgComplete, 9 cfgIdle.
- link_number  in  8  link number this port proposes (downstream) or has accepted.
- lane_number  in  8  lane number for this lane.
- rate_id  in  8  data-rate identifier, placed in byte 4.
- upconfigure  in  1  upconfigure capability, placed in bit 42.
- rx_link  in  8  link number from the receive checker.
- rx_link_valid  in  1  rx_link holds a non-PAD link number.
- orderedset  out  128  ordered set; byte k = bits [8k+7:8k].
- os_valid  out  1  orderedset is valid.
- os_ready  in  1  serializer accepts the set on this cycle when os_valid is also high.
- sent_count  out  11  sets accepted in the current substate; saturates at 2047.
- min_sent  out  1  sent_count >= the minimum for the current substate.

## Operation
- Set layout:
  - byte 0: 8'h1E for TS1, 8'h2D for TS2.
  - byte 1: link field.
  - byte 2: lane field.
  - byte 3: 8'h00 (N_FTS).
  - byte 4: rate_id.
  - byte 5: bit 42 = upconfigure; all other bits 0.
  - bytes 6–15: identifier, 8'h2A for TS1 and 8'h25 for TS2.
  - Idle set: all 128 bits zero.
- Content per substate (PAD = 8'hF7):
  - Substates 0–1, and any encoding ≥10: nothing is transmitted.
  - pollingActive: TS1 with link PAD, lane PAD.
  - pollingConfiguration: TS2 with link PAD, lane PAD.
  - cfgLinkWidthStart: TS1, lane PAD. Downstream sends link_number; upstream sends link PAD.
  - cfgLinkWidthAccept: TS1, lane PAD. Downstream sends link_number; upstream sends captured_link.
  - cfgLanenumWait and cfgLanenumAccept: TS1 with link_number and lane_number.
  - cfgComplete: TS2 with link_number and lane_number.
  - cfgIdle: Idle set.
- captured_link (upstream only):
  - Loaded from rx_link when rx_link_valid is high in cfgLinkWidthStart or cfgLinkWidthAccept.
  - Reset value 8'hF7.
  - Reloaded to 8'hF7 when substate is below 4.
- FSM states:
  - OFF: os_valid = 0. Go to SEND when substate transmits.
  - SEND: the output register loads a new set whenever it is empty or accepted this cycle (!os_valid || os_ready). If substate becomes non-transmitting while a set is held unaccepted, go to DRAIN. If it becomes non-transmitting with nothing held, or on the cycle the held set is accepted, go to OFF.
  - DRAIN: hold the set until accepted, then clear os_valid and go to OFF.
- Hold rule: a held set is never modified or dropped. orderedset stays stable while os_valid && !os_ready.
- Counter:
  - Increments on each accept (os_valid && os_ready) whose set was built in the current substate.
  - Clears to 0 on the cycle after substate changes (substate != registered previous substate).
  - Accepting a stale set from the old substate does not count.
- min_sent:
  - pollingActive: sent_count ≥ POLL_ACTIVE_MIN.
  - States 3, 8, 9: sent_count ≥ TS_MIN.
  - States 4–7: sent_count ≥ 1.
  - Otherwise 0.

## Timing
- Reset values: os_valid 0, orderedset 0, sent_count 0, min_sent 0, captured_link 8'hF7, FSM OFF, registered previous substate 0.
- Latency: a substate change sampled at edge N produces a new-substate set with os_valid high after edge N+1, provided the output register is free.
- Back-to-back: with os_ready held high, one set is transferred every cycle with no bubbles.
- Substate change while a set is held: the old set completes first, and the new content follows on the cycle after it is accepted.
- sent_count and min_sent are registered and update one cycle after the accept.
- Reset asserted mid-hold: the set is discarded and all outputs return to reset values on the next edge.

## Structure
- Shared package ltssm_pkg holds:
  - substate encodings;
  - PAD, TS1_ID, TS2_ID, TS1_SYM0 and TS2_SYM0 constants;
  - the os_kind enum: NONE, TS1, TS2, IDLE.
- Natural sub-module: os_builder, purely combinational. It maps (kind, link, lane, rate_id, upconfigure) to the 128-bit set.
- os_generator contains the FSM, output register, counter and captured_link register.

## Test plan
- Reset, then substate = 2 with os_ready = 1: orderedset[7:0] = 8'h1E, [15:8] = [23:16] = 8'hF7, [87:80] = 8'h2A. min_sent rises after exactly 1024 accepts.
- Substate = 8 with link 8'h03, lane 8'h01, rate_id 8'h1F, upconfigure 1: each set has [15:8] = 03, [23:16] = 01, [39:32] = 1F, bit 42 = 1, [87:80] = 8'h25. min_sent asserts after 16 accepts.
- DEVICETYPE = 1:
  - in substate 4, rx_link_valid with rx_link = 8'h05; then substate 5;
  - required: [15:8] is F7 in substate 4 and 05 in substate 5.
- os_ready held 0 for 10 cycles while substate changes from 2 to 3: orderedset stays constant as TS1. After accept, TS2 appears and sent_count starts from 0.
- Substate = 9: orderedset is all zeros. Switching to 0 with a set held: that set stays until accepted (DRAIN), then os_valid = 0.
- Reset pulse during a hold: os_valid = 0 and sent_count = 0 on the next cycle.

Source files
------------

// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate encodings, ordered-set symbols and set kinds.
// Used by both the transmit generator and the receive checker.
package ltssm_pkg;

    localparam logic [3:0] SUB_DETECT_QUIET       = 4'd0;
    localparam logic [3:0] SUB_DETECT_ACTIVE      = 4'd1;
    localparam logic [3:0] SUB_POLL_ACTIVE        = 4'd2;
    localparam logic [3:0] SUB_POLL_CONFIG        = 4'd3;
    localparam logic [3:0] SUB_CFG_LW_START       = 4'd4;
    localparam logic [3:0] SUB_CFG_LW_ACCEPT      = 4'd5;
    localparam logic [3:0] SUB_CFG_LANENUM_WAIT   = 4'd6;
    localparam logic [3:0] SUB_CFG_LANENUM_ACCEPT = 4'd7;
    localparam logic [3:0] SUB_CFG_COMPLETE       = 4'd8;
    localparam logic [3:0] SUB_CFG_IDLE           = 4'd9;

    localparam logic [7:0] PAD      = 8'hF7;
    localparam logic [7:0] TS1_ID   = 8'h2A;
    localparam logic [7:0] TS2_ID   = 8'h25;
    localparam logic [7:0] TS1_SYM0 = 8'h1E;
    localparam logic [7:0] TS2_SYM0 = 8'h2D;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        TS1  = 2'd1,
        TS2  = 2'd2,
        IDLE = 2'd3
    } os_kind_e;

    // Which kind of set a substate transmits; NONE means the lane is silent.
    function automatic os_kind_e substate_kind(input logic [3:0] sub);
        os_kind_e k;
        case (sub)
            SUB_POLL_ACTIVE,
            SUB_CFG_LW_START,
            SUB_CFG_LW_ACCEPT,
            SUB_CFG_LANENUM_WAIT,
            SUB_CFG_LANENUM_ACCEPT: k = TS1;
            SUB_POLL_CONFIG,
            SUB_CFG_COMPLETE:       k = TS2;
            SUB_CFG_IDLE:           k = IDLE;
            default:                k = NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/os_builder.sv
// Combinational formatter: turns a set kind plus field values into the 128-bit
// ordered set, byte k on bits [8k+7:8k].
module os_builder
    import ltssm_pkg::*;
(
    input  logic [1:0]   kind,
    input  logic [7:0]   link,
    input  logic [7:0]   lane,
    input  logic [7:0]   rate_id,
    input  logic         upconfigure,
    output logic [127:0] os_set
);

    os_kind_e   kind_e_s;
    logic [7:0] sym0_s;
    logic [7:0] ident_s;

    assign kind_e_s = os_kind_e'(kind);

    // Select the kind-dependent symbols
    always_comb begin
        sym0_s  = TS1_SYM0;
        ident_s = TS1_ID;
        if (kind_e_s == TS2) begin
            sym0_s  = TS2_SYM0;
            ident_s = TS2_ID;
        end else begin
            sym0_s  = TS1_SYM0;
            ident_s = TS1_ID;
        end
    end

    // Assemble the set; Idle and NONE both come out all-zero
    always_comb begin
        os_set = 128'b0;
        case (kind_e_s)
            TS1, TS2: begin
                os_set[7:0]   = sym0_s;
                os_set[15:8]  = link;
                os_set[23:16] = lane;
                os_set[31:24] = 8'h00;
                os_set[39:32] = rate_id;
                os_set[42]    = upconfigure;
                for (int k = 6; k < 16; k++) begin
                    os_set[8*k +: 8] = ident_s;
                end
            end
            default: os_set = 128'b0;
        endcase
    end

endmodule

// File: rtl/os_generator.sv
// Transmit-side ordered-set generator: emits TS1/TS2/Idle sets for the current
// LTSSM substate over a valid/ready handshake and tracks how many were sent.
module os_generator
    import ltssm_pkg::*;
#(
    parameter int DEVICETYPE      = 0,
    parameter int POLL_ACTIVE_MIN = 1024,
    parameter int TS_MIN          = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   substate,
    input  logic [7:0]   link_number,
    input  logic [7:0]   lane_number,
    input  logic [7:0]   rate_id,
    input  logic         upconfigure,
    input  logic [7:0]   rx_link,
    input  logic         rx_link_valid,
    output logic [127:0] orderedset,
    output logic         os_valid,
    input  logic         os_ready,
    output logic [10:0]  sent_count,
    output logic         min_sent
);

    localparam bit         UPSTREAM   = (DEVICETYPE != 0);
    localparam logic [11:0] POLL_MIN_W = 12'(POLL_ACTIVE_MIN);
    localparam logic [11:0] TS_MIN_W   = 12'(TS_MIN);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } gen_state_e;

    gen_state_e   state_r;
    gen_state_e   state_next_s;
    logic [3:0]   prev_sub_r;
    logic [3:0]   set_sub_r;
    logic [7:0]   captured_link_r;
    logic [127:0] orderedset_r;
    logic         os_valid_r;
    logic [10:0]  count_r;
    logic         min_sent_r;

    os_kind_e     kind_s;
    logic         transmit_s;
    logic         accept_s;
    logic         load_s;
    logic         clear_valid_s;
    logic [7:0]   link_field_s;
    logic [7:0]   lane_field_s;
    logic [127:0] built_s;
    logic [10:0]  count_next_s;
    logic         min_next_s;

    assign kind_s     = substate_kind(substate);
    assign transmit_s = (kind_s != NONE);
    assign accept_s   = os_valid_r && os_ready;

    // Link and lane fields for the current substate and port direction
    always_comb begin
        link_field_s = PAD;
        lane_field_s = PAD;
        case (substate)
            SUB_CFG_LW_START: begin
                if (UPSTREAM) begin
                    link_field_s = PAD;
                end else begin
                    link_field_s = link_number;
                end
            end
            SUB_CFG_LW_ACCEPT: begin
                if (UPSTREAM) begin
                    link_field_s = captured_link_r;
                end else begin
                    link_field_s = link_number;
                end
            end
            SUB_CFG_LANENUM_WAIT,
            SUB_CFG_LANENUM_ACCEPT,
            SUB_CFG_COMPLETE: begin
                link_field_s = link_number;
                lane_field_s = lane_number;
            end
            default: begin
                link_field_s = PAD;
                lane_field_s = PAD;
            end
        endcase
    end

    os_builder u_builder (
        .kind        (kind_s),
        .link        (link_field_s),
        .lane        (lane_field_s),
        .rate_id     (rate_id),
        .upconfigure (upconfigure),
        .os_set      (built_s)
    );

    // Handshake FSM: next state plus load/clear strobes for the output register
    always_comb begin
        state_next_s  = state_r;
        load_s        = 1'b0;
        clear_valid_s = 1'b0;
        case (state_r)
            OFF: begin
                if (transmit_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = OFF;
                end
            end
            SEND: begin
                if (!os_valid_r || os_ready) begin
                    if (transmit_s) begin
                        load_s       = 1'b1;
                        state_next_s = SEND;
                    end else begin
                        clear_valid_s = 1'b1;
                        state_next_s  = OFF;
                    end
                end else if (!transmit_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = SEND;
                end
            end
            DRAIN: begin
                if (os_ready) begin
                    clear_valid_s = 1'b1;
                    state_next_s  = OFF;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                clear_valid_s = 1'b1;
                state_next_s  = OFF;
            end
        endcase
    end

    // Sent counter: restart on substate change, ignore stale sets, saturate
    always_comb begin
        count_next_s = count_r;
        if (substate != prev_sub_r) begin
            count_next_s = 11'd0;
        end else if (accept_s && (set_sub_r == substate) && (count_r != 11'h7FF)) begin
            count_next_s = count_r + 11'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Transmit-minimum threshold for the current substate
    always_comb begin
        min_next_s = 1'b0;
        case (substate)
            SUB_POLL_ACTIVE:  min_next_s = ({1'b0, count_next_s} >= POLL_MIN_W);
            SUB_POLL_CONFIG,
            SUB_CFG_COMPLETE,
            SUB_CFG_IDLE:     min_next_s = ({1'b0, count_next_s} >= TS_MIN_W);
            SUB_CFG_LW_START,
            SUB_CFG_LW_ACCEPT,
            SUB_CFG_LANENUM_WAIT,
            SUB_CFG_LANENUM_ACCEPT: min_next_s = (count_next_s != 11'd0);
            default:          min_next_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= OFF;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output register; a held set is only replaced once accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            orderedset_r <= 128'b0;
            os_valid_r   <= 1'b0;
            set_sub_r    <= 4'd0;
        end else if (load_s) begin
            orderedset_r <= built_s;
            os_valid_r   <= 1'b1;
            set_sub_r    <= substate;
        end else if (clear_valid_s) begin
            os_valid_r   <= 1'b0;
        end
    end

    // Counter, threshold flag and previous-substate tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r    <= 11'd0;
            min_sent_r <= 1'b0;
            prev_sub_r <= 4'd0;
        end else begin
            count_r    <= count_next_s;
            min_sent_r <= min_next_s;
            prev_sub_r <= substate;
        end
    end

    // Upstream port remembers the link number offered by the downstream partner
    always_ff @(posedge clk) begin
        if (reset) begin
            captured_link_r <= PAD;
        end else if (substate < SUB_CFG_LW_START) begin
            captured_link_r <= PAD;
        end else if (UPSTREAM && rx_link_valid &&
                     ((substate == SUB_CFG_LW_START) || (substate == SUB_CFG_LW_ACCEPT))) begin
            captured_link_r <= rx_link;
        end
    end

    assign orderedset = orderedset_r;
    assign os_valid   = os_valid_r;
    assign sent_count = count_r;
    assign min_sent   = min_sent_r;

endmodule

// File: tb/tb_os_generator.sv
// Self-checking bench for os_generator: a downstream and an upstream instance
// share stimulus and are compared each cycle against a transaction-level model.
module tb_os_generator;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   substate;
    logic [7:0]   link_number, lane_number, rate_id, rx_link;
    logic         upconfigure, rx_link_valid, os_ready;

    logic [127:0] os0, os1;
    logic         v0, v1, min0, min1;
    logic [10:0]  cnt0, cnt1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    os_generator #(.DEVICETYPE(0), .POLL_ACTIVE_MIN(1024), .TS_MIN(16)) dut0 (
        .clk(clk), .reset(reset), .substate(substate), .link_number(link_number),
        .lane_number(lane_number), .rate_id(rate_id), .upconfigure(upconfigure),
        .rx_link(rx_link), .rx_link_valid(rx_link_valid), .orderedset(os0),
        .os_valid(v0), .os_ready(os_ready), .sent_count(cnt0), .min_sent(min0));

    os_generator #(.DEVICETYPE(1), .POLL_ACTIVE_MIN(1024), .TS_MIN(16)) dut1 (
        .clk(clk), .reset(reset), .substate(substate), .link_number(link_number),
        .lane_number(lane_number), .rate_id(rate_id), .upconfigure(upconfigure),
        .rx_link(rx_link), .rx_link_valid(rx_link_valid), .orderedset(os1),
        .os_valid(v1), .os_ready(os_ready), .sent_count(cnt1), .min_sent(min1));

    typedef struct packed {
        logic         v;
        logic [127:0] set;
        logic [3:0]   sub;
        logic         run;
        logic         drain;
        logic [10:0]  cnt;
        logic         min;
        logic [7:0]   cap;
        logic [3:0]   prev;
    } model_t;

    model_t m0, m1;

    // The set a substate should carry, built byte by byte from the layout table
    function automatic logic [127:0] expect_set(input bit up, input logic [3:0] s, input logic [7:0] cap);
        logic [7:0]   b [16];
        logic [127:0] r;
        bit           ts2;
        r = 128'b0;
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        if (s >= 4'd2 && s <= 4'd8) begin
            ts2  = (s == 4'd3) || (s == 4'd8);
            b[0] = ts2 ? 8'h2D : 8'h1E;
            b[1] = 8'hF7;
            b[2] = 8'hF7;
            if (s >= 4'd6) begin
                b[1] = link_number;
                b[2] = lane_number;
            end else if (s == 4'd4) begin
                b[1] = up ? 8'hF7 : link_number;
            end else if (s == 4'd5) begin
                b[1] = up ? cap : link_number;
            end
            b[4] = rate_id;
            b[5] = upconfigure ? 8'h04 : 8'h00;
            for (int i = 6; i < 16; i++) b[i] = ts2 ? 8'h25 : 8'h2A;
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic model_t next_model(input model_t c, input bit up);
        model_t n;
        bit     tx, acc;
        n = c;
        if (reset) begin
            n     = '0;
            n.cap = 8'hF7;
            return n;
        end
        tx  = (substate >= 4'd2) && (substate <= 4'd9);
        acc = c.v && os_ready;
        if (substate < 4'd4) n.cap = 8'hF7;
        else if (up && rx_link_valid && (substate == 4'd4 || substate == 4'd5)) n.cap = rx_link;
        if (substate != c.prev) n.cnt = 11'd0;
        else if (acc && c.sub == substate && c.cnt != 11'd2047) n.cnt = c.cnt + 11'd1;
        n.prev = substate;
        if (substate == 4'd2) n.min = (n.cnt >= 11'd1024);
        else if (substate == 4'd3 || substate == 4'd8 || substate == 4'd9) n.min = (n.cnt >= 11'd16);
        else if (substate >= 4'd4 && substate <= 4'd7) n.min = (n.cnt >= 11'd1);
        else n.min = 1'b0;
        if (c.v && !acc) begin
            if (!tx) n.drain = 1'b1;
        end else if (c.run && !c.drain && tx) begin
            n.v   = 1'b1;
            n.set = expect_set(up, substate, c.cap);
            n.sub = substate;
        end else begin
            n.v     = 1'b0;
            n.run   = !c.run && tx;
            n.drain = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= next_model(m0, 1'b0);
        m1 <= next_model(m1, 1'b1);
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid0", v0, m0.v);
            chk("m_valid1", v1, m1.v);
            if (m0.v) chk("m_set0", os0, m0.set);
            if (m1.v) chk("m_set1", os1, m1.set);
            chk("m_cnt0", cnt0, m0.cnt);
            chk("m_cnt1", cnt1, m1.cnt);
            chk("m_min0", min0, m0.min);
            chk("m_min1", min1, m1.min);
        end
    end

    logic [127:0] held;
    int           n;
    bit           done;

    initial begin
        reset = 1'b1; substate = 4'd0; link_number = 8'h00; lane_number = 8'h00;
        rate_id = 8'h00; upconfigure = 1'b0; rx_link = 8'h00; rx_link_valid = 1'b0;
        os_ready = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", v0, 1'b0);
        chk("rst_set", os0, 128'b0);
        chk("rst_cnt", cnt0, 11'd0);
        chk("rst_min", min0, 1'b0);

        // pollingActive: TS1 with PAD fields, minimum after exactly 1024 accepts
        reset = 1'b0; substate = 4'd2; os_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 5 && !done; i++) begin
            @(negedge clk);
            done = v0;
        end
        if (!done) begin errors++; $display("FAIL poll_start got=0 want=1"); end
        chk("poll_sym0", os0[7:0], 8'h1E);
        chk("poll_link", os0[15:8], 8'hF7);
        chk("poll_lane", os0[23:16], 8'hF7);
        chk("poll_id", os0[87:80], 8'h2A);
        n = 0; done = 1'b0;
        for (int i = 0; i < 1100 && !done; i++) begin
            if (n == 1023) chk("poll_min_1023", min0, 1'b0);
            if (n == 1024) begin
                chk("poll_min_1024", min0, 1'b1);
                chk("poll_cnt_1024", cnt0, 11'd1024);
                done = 1'b1;
            end else begin
                if (v0) n++;
                @(negedge clk);
            end
        end
        if (!done) begin errors++; $display("FAIL poll_timeout got=%0d want=1024", n); end

        // cfgComplete: TS2 with real fields, minimum after 16 accepts
        substate = 4'd8; link_number = 8'h03; lane_number = 8'h01;
        rate_id = 8'h1F; upconfigure = 1'b1;
        @(negedge clk);
        chk("cpl_sym0", os0[7:0], 8'h2D);
        chk("cpl_link", os0[15:8], 8'h03);
        chk("cpl_lane", os0[23:16], 8'h01);
        chk("cpl_rate", os0[39:32], 8'h1F);
        chk("cpl_upcfg", os0[42], 1'b1);
        chk("cpl_id", os0[87:80], 8'h25);
        repeat (15) @(negedge clk);
        chk("cpl_cnt_15", cnt0, 11'd15);
        chk("cpl_min_15", min0, 1'b0);
        @(negedge clk);
        chk("cpl_min_16", min0, 1'b1);

        // Link-width negotiation: upstream echoes the captured partner link
        substate = 4'd4; link_number = 8'h09; rx_link = 8'h05; rx_link_valid = 1'b1;
        upconfigure = 1'b0;
        @(negedge clk);
        chk("lws_up_link", os1[15:8], 8'hF7);
        chk("lws_dn_link", os0[15:8], 8'h09);
        rx_link_valid = 1'b0; substate = 4'd5;
        @(negedge clk);
        chk("lwa_up_link", os1[15:8], 8'h05);
        chk("lwa_dn_link", os0[15:8], 8'h09);

        // Held TS1 survives a change to pollingConfiguration
        substate = 4'd2;
        repeat (3) @(negedge clk);
        os_ready = 1'b0;
        @(negedge clk);
        held = os0;
        substate = 4'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_stable", os0, held);
            chk("hold_sym0", os0[7:0], 8'h1E);
        end
        os_ready = 1'b1;
        @(negedge clk);
        chk("hold_next_sym0", os0[7:0], 8'h2D);
        chk("hold_next_cnt", cnt0, 11'd0);
        @(negedge clk);
        chk("hold_next_cnt1", cnt0, 11'd1);

        // cfgIdle sends zeros; drain a held TS1 when leaving for detectQuiet
        substate = 4'd9;
        repeat (2) @(negedge clk);
        chk("idle_valid", v0, 1'b1);
        chk("idle_set", os0, 128'b0);
        substate = 4'd2;
        repeat (2) @(negedge clk);
        os_ready = 1'b0;
        @(negedge clk);
        held = os0;
        substate = 4'd0;
        repeat (3) @(negedge clk);
        chk("drain_valid", v0, 1'b1);
        chk("drain_set", os0, held);
        os_ready = 1'b1;
        @(negedge clk);
        chk("drain_done", v0, 1'b0);
        @(negedge clk);
        chk("drain_off", v0, 1'b0);

        // Reset pulse while a set is held
        substate = 4'd3;
        repeat (3) @(negedge clk);
        os_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", v0, 1'b0);
        chk("rstmid_cnt", cnt0, 11'd0);
        chk("rstmid_min", min0, 1'b0);
        reset = 1'b0; substate = 4'd0; os_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
